// File: rtl/login_sequencer.sv
// login_sequencer: ID/password login handshake with grant timeout, failure counting and lockout.
module login_sequencer #(
  parameter int unsigned MAX_ATTEMPTS   = 3,
  parameter int unsigned GRANT_WAIT     = 16,
  parameter int unsigned DENY_HOLD      = 25_000_000,
  parameter int unsigned LOCKOUT_CYCLES = 250_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        enter,
  input  logic        logout,
  input  logic [15:0] switches,
  input  logic        access_grant,
  output logic [17:0] data_out,
  output logic        data_load,
  output logic [15:0] user_id,
  output logic        session_active,
  output logic        locked,
  output logic [1:0]  led,
  output logic [3:0]  lcd_select,
  output logic [2:0]  fail_count
);
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ID_ENTRY = 4'd1,
    PW_ENTRY = 4'd2,
    CHECK    = 4'd3,
    GRANTED  = 4'd4,
    DENIED   = 4'd5,
    LOCKED   = 4'd6
  } state_t;
  localparam logic [31:0] GW_T   = 32'(GRANT_WAIT - 1);
  localparam logic [31:0] DH_T   = 32'(DENY_HOLD - 1);
  localparam logic [31:0] LK_T   = 32'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0]  MAX_FC = 3'(MAX_ATTEMPTS);
  state_t      state, state_n;
  logic [31:0] cnt, cnt_n;
  logic [2:0]  fail_n;
  logic        load;
  always_comb begin
    state_n = state;
    fail_n  = fail_count;
    load    = 1'b0;
    case (state)
      IDLE:     if (start) state_n = ID_ENTRY;
      ID_ENTRY: if (logout) state_n = IDLE;
                else if (enter) begin
                  state_n = PW_ENTRY;
                  load    = 1'b1;
                end
      PW_ENTRY: if (logout) state_n = IDLE;
                else if (enter) begin
                  state_n = CHECK;
                  load    = 1'b1;
                end
      CHECK:    if (logout) state_n = IDLE;
                else if (access_grant) begin
                  state_n = GRANTED;
                  fail_n  = '0;
                end else if (cnt == GW_T) begin
                  fail_n  = fail_count + 3'd1;
                  state_n = (fail_n == MAX_FC) ? LOCKED : DENIED;
                end
      GRANTED:  if (logout) state_n = IDLE;
      DENIED:   if (logout) state_n = IDLE;
                else if (cnt == DH_T) state_n = ID_ENTRY;
      LOCKED:   if (cnt == LK_T) begin
                  state_n = IDLE;
                  fail_n  = '0;
                end
      default:  state_n = IDLE;
    endcase
    // every timed state is entered from a different state, so a change reloads the timer
    cnt_n = (state_n != state) ? '0 : cnt + 32'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      fail_count     <= '0;
      data_out       <= '0;
      data_load      <= 1'b0;
      user_id        <= '0;
      session_active <= 1'b0;
      locked         <= 1'b0;
      led            <= 2'b00;
      lcd_select     <= '0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      fail_count     <= fail_n;
      data_load      <= load;
      if (load) data_out <= {2'b00, switches};
      if (load && state == ID_ENTRY) user_id <= switches;
      session_active <= state_n == GRANTED;
      locked         <= state_n == LOCKED;
      led            <= {state_n == GRANTED, state_n == DENIED || state_n == LOCKED};
      lcd_select     <= state_n;
    end
  end
endmodule
